// File: rtl/motor_pkg.sv
// Shared types and defaults for the motor duty ramp and the PWM counter.
package motor_pkg;

  localparam int DUTY_W       = 32;
  localparam int DEF_PERIOD   = 1250;  // PWM counter counts 0..PERIOD
  localparam int DEF_MAX_DUTY = 1251;  // PERIOD+1 = 100% on

  typedef enum logic [1:0] {IDLE, RUN, REV_DOWN, DEAD} state_e;

  // Clamp a commanded duty to the allowed maximum.
  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] d,
                                                   input logic [DUTY_W-1:0] m);
    return (d > m) ? m : d;
  endfunction

endpackage

// File: rtl/motor_duty_ramp_if.sv
// CPU command handshake for the motor duty ramp.
interface motor_duty_ramp_if;
  import motor_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DUTY_W-1:0] cmd_duty;
  logic              cmd_dir;

  modport master (output cmd_valid, output cmd_duty, output cmd_dir, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_duty, input  cmd_dir, output cmd_ready);
endinterface

// File: rtl/motor_duty_ramp_slew_step.sv
// One saturating slew step: move duty toward target by at most step,
// never passing the target and never wrapping below zero.
module duty_slew_step
  import motor_pkg::*;
(
  input  logic [DUTY_W-1:0] duty_i,
  input  logic [DUTY_W-1:0] target_i,
  input  logic [DUTY_W-1:0] step_i,
  output logic [DUTY_W-1:0] next_o
);

  logic [DUTY_W-1:0] diff;
  logic [DUTY_W-1:0] amt;

  // Magnitude of the gap, limited to one step, applied in the right direction.
  always_comb begin
    diff   = (duty_i < target_i) ? (target_i - duty_i) : (duty_i - target_i);
    amt    = (diff > step_i) ? step_i : diff;
    next_o = (duty_i < target_i) ? (duty_i + amt) : (duty_i - amt);
  end

endmodule

// File: rtl/motor_duty_ramp.sv
// Motor duty ramp: slew-limits CPU duty commands once per PWM period and
// sequences direction reversals through ramp-down, a dead interval and flip.
// Optional watchdog: define RAMP_WATCHDOG_EN to ramp to idle when commands stop.
module motor_duty_ramp
  import motor_pkg::*;
#(
  parameter int PERIOD     = DEF_PERIOD,
  parameter int MAX_DUTY   = DEF_MAX_DUTY,
  parameter int STEP       = 25,
  parameter int DEAD_TICKS = 4,
  parameter int WDT_TICKS  = 400
) (
  input  logic              clk,
  input  logic              rst,
  motor_duty_ramp_if.slave  cmd,
  output logic [DUTY_W-1:0] duty,
  output logic              enable,
  output logic              dir,
  output logic              tick,
  output logic              busy,
  output logic              timeout
);

  localparam int CW = $clog2(PERIOD + 1);
  localparam int DW = $clog2(DEAD_TICKS + 2);

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic              tick_q;
  logic [DUTY_W-1:0] duty_q;
  logic [DUTY_W-1:0] target_q;
  logic              tgt_dir_q;
  logic              enable_q;
  logic              dir_q;
  logic [DW-1:0]     dead_q;
  logic              timeout_q;

  logic              accept;
  logic [DUTY_W-1:0] clamped;
  logic [DUTY_W-1:0] slew_tgt;
  logic [DUTY_W-1:0] slew_next;
  logic              wdt_fire;

  assign cmd.cmd_ready = (state_q != REV_DOWN) && (state_q != DEAD);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign clamped       = clamp_duty(cmd.cmd_duty, DUTY_W'(MAX_DUTY));
  // Outside RUN the only ramp is down to zero; the target is kept for later.
  assign slew_tgt      = (state_q == RUN) ? target_q : '0;

  duty_slew_step u_slew (
    .duty_i   (duty_q),
    .target_i (slew_tgt),
    .step_i   (DUTY_W'(STEP)),
    .next_o   (slew_next)
  );

  // Free-running PWM period counter with a registered end-of-period pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (cnt_q == CW'(PERIOD));
      cnt_q  <= (cnt_q == CW'(PERIOD)) ? '0 : cnt_q + 1'b1;
    end
  end

`ifdef RAMP_WATCHDOG_EN
  localparam int WW = $clog2(WDT_TICKS + 2);
  logic [WW-1:0] wdt_q;

  // Fires once when the tick count since the last command hits the limit.
  assign wdt_fire = (wdt_q == WW'(WDT_TICKS)) && !timeout_q && !accept;

  // Ticks since last accepted command, counted only while the motor is active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdt_q     <= '0;
      timeout_q <= 1'b0;
    end else if (accept) begin
      wdt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (wdt_fire) timeout_q <= 1'b1;
      if (tick_q && (state_q != IDLE) && (wdt_q != WW'(WDT_TICKS)))
        wdt_q <= wdt_q + 1'b1;
    end
  end
`else
  logic unused_wdt;
  assign unused_wdt = ^(32'(WDT_TICKS));
  assign wdt_fire   = 1'b0;
  assign timeout_q  = 1'b0;
`endif

  // Command capture and ramp/reversal sequencing; outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      duty_q    <= '0;
      target_q  <= '0;
      tgt_dir_q <= 1'b1;
      enable_q  <= 1'b0;
      dir_q     <= 1'b1;
      dead_q    <= '0;
    end else begin
      if (accept) begin
        target_q  <= clamped;
        tgt_dir_q <= cmd.cmd_dir;
      end else if (wdt_fire) begin
        target_q  <= '0;
      end

      case (state_q)
        IDLE: begin
          duty_q   <= '0;
          enable_q <= 1'b0;
          if (accept && (clamped != '0)) begin
            dir_q    <= cmd.cmd_dir;
            enable_q <= 1'b1;
            state_q  <= RUN;
          end
        end

        RUN: begin
          if (accept && (cmd.cmd_dir != dir_q)) begin
            if (duty_q != '0) begin
              state_q <= REV_DOWN;
              if (tick_q) duty_q <= slew_next;
            end else begin
              // Already at zero: flip now and start the new ramp next tick.
              dir_q <= cmd.cmd_dir;
            end
          end else if (tick_q) begin
            if ((duty_q == '0) && (target_q == '0) && !accept) begin
              enable_q <= 1'b0;
              state_q  <= IDLE;
            end else begin
              duty_q <= slew_next;
            end
          end
        end

        REV_DOWN: begin
          if (duty_q == '0) begin
            enable_q <= 1'b0;
            dead_q   <= '0;
            state_q  <= DEAD;
          end else if (tick_q) begin
            duty_q <= slew_next;
          end
        end

        DEAD: begin
          if (dead_q == DW'(DEAD_TICKS)) begin
            dir_q    <= tgt_dir_q;
            enable_q <= 1'b1;
            state_q  <= RUN;
          end else if (tick_q) begin
            dead_q <= dead_q + 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign duty    = duty_q;
  assign enable  = enable_q;
  assign dir     = dir_q;
  assign tick    = tick_q;
  assign busy    = (state_q == REV_DOWN) || (state_q == DEAD);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_motor_duty_ramp.sv
// Directed bench for motor_duty_ramp with PERIOD=9, MAX_DUTY=10, STEP=3,
// DEAD_TICKS=2, WDT_TICKS=5. Watchdog checks follow RAMP_WATCHDOG_EN.
module tb_motor_duty_ramp;
  import motor_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DUTY_W-1:0] duty;
  logic              enable, dir, tick, busy, timeout;
  int                total = 0;
  int                bad   = 0;

  motor_duty_ramp_if cif ();

  motor_duty_ramp #(
    .PERIOD(9), .MAX_DUTY(10), .STEP(3), .DEAD_TICKS(2), .WDT_TICKS(5)
  ) dut (
    .clk(clk), .rst(rst), .cmd(cif),
    .duty(duty), .enable(enable), .dir(dir), .tick(tick),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Wait for the next tick pulse, then sample the cycle after it has acted.
  task automatic tick_upd();
    bit seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tick) begin seen = 1; break; end
    end
    if (!seen) chk("tick_timeout", 0, 1);
    @(negedge clk);
  endtask

  // One-cycle command, issued from a negedge; returns at the next negedge.
  task automatic send(input logic [31:0] d, input logic dr);
    chk("send_ready", cif.cmd_ready, 1);
    cif.cmd_duty  = d;
    cif.cmd_dir   = dr;
    cif.cmd_valid = 1'b1;
    @(negedge clk);
    cif.cmd_valid = 1'b0;
  endtask

  initial begin
    cif.cmd_valid = 1'b0;
    cif.cmd_duty  = '0;
    cif.cmd_dir   = 1'b1;

    // reset values
    @(negedge clk);
    chk("rst_duty", duty, 0);     chk("rst_en", enable, 0);
    chk("rst_dir", dir, 1);       chk("rst_tick", tick, 0);
    chk("rst_busy", busy, 0);     chk("rst_to", timeout, 0);
    chk("rst_ready", cif.cmd_ready, 1);
    rst = 1'b0;

    // ramp up from idle to 8
    send(8, 1);
    chk("up_en", enable, 1);  chk("up_dir", dir, 1);  chk("up_duty0", duty, 0);
    tick_upd(); chk("up_3", duty, 3);
    tick_upd(); chk("up_6", duty, 6);
    tick_upd(); chk("up_8", duty, 8);
    tick_upd(); chk("up_hold", duty, 8);

    // ramp down to 2 without undershoot
    send(2, 1);
    chk("dn_nochg", duty, 8);
    tick_upd(); chk("dn_5", duty, 5);
    tick_upd(); chk("dn_2", duty, 2);
    tick_upd(); chk("dn_hold", duty, 2);

    send(8, 1);
    tick_upd(); chk("re_5", duty, 5);
    tick_upd(); chk("re_8", duty, 8);

    // direction reversal
    send(6, 0);
    chk("rev_busy", busy, 1);  chk("rev_ready", cif.cmd_ready, 0);  chk("rev_dir", dir, 1);
    tick_upd(); chk("rev_5", duty, 5);
    tick_upd(); chk("rev_2", duty, 2);
    tick_upd(); chk("rev_0", duty, 0);  chk("rev_en0", enable, 1);
    @(negedge clk);
    chk("dead_en", enable, 0);  chk("dead_busy", busy, 1);
    tick_upd(); chk("dead1_en", enable, 0);  chk("dead1_dir", dir, 1);
    tick_upd(); chk("dead2_en", enable, 0);  chk("dead2_dir", dir, 1);
    @(negedge clk);
    chk("flip_dir", dir, 0);  chk("flip_en", enable, 1);
    chk("flip_busy", busy, 0);  chk("flip_duty", duty, 0);
    tick_upd(); chk("fwd_3", duty, 3);
    tick_upd(); chk("fwd_6", duty, 6);

    // clamp
    send(50, 0);
    tick_upd(); chk("clp_9", duty, 9);
    tick_upd(); chk("clp_10", duty, 10);
    tick_upd(); chk("clp_hold", duty, 10);

    // reverse again and reset in the dead interval
    send(0, 1);
    tick_upd(); chk("r2_7", duty, 7);
    tick_upd(); chk("r2_4", duty, 4);
    tick_upd(); chk("r2_1", duty, 1);
    tick_upd(); chk("r2_0", duty, 0);
    tick_upd(); chk("r2_dead_en", enable, 0);  chk("r2_dead_dir", dir, 0);
    rst = 1'b1;
    #1;
    chk("mr_duty", duty, 0);  chk("mr_en", enable, 0);  chk("mr_dir", dir, 1);
    chk("mr_busy", busy, 0);  chk("mr_tick", tick, 0);  chk("mr_ready", cif.cmd_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    tick_upd();
    chk("idle_en", enable, 0);  chk("idle_duty", duty, 0);
    chk("idle_busy", busy, 0);  chk("idle_ready", cif.cmd_ready, 1);

    // command timeout
    send(6, 1);
    tick_upd(); chk("wd_3", duty, 3);
    tick_upd(); chk("wd_6", duty, 6);
    tick_upd(); tick_upd(); tick_upd();
    chk("wd_pre", timeout, 0);
    @(negedge clk);
`ifdef RAMP_WATCHDOG_EN
    chk("wd_fire", timeout, 1);
    tick_upd(); chk("wd_d3", duty, 3);
    tick_upd(); chk("wd_d0", duty, 0);
    tick_upd(); chk("wd_idle_en", enable, 0);  chk("wd_idle_busy", busy, 0);
    send(4, 1);
    chk("wd_clr", timeout, 0);  chk("wd_en", enable, 1);
`else
    chk("wd_none", timeout, 0);
    tick_upd(); chk("wd_hold", duty, 6);  chk("wd_en", enable, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/motor_duty_ramp.md
Name: motor_duty_ramp

Overview:
- Upstream of the motor PWM counter. Takes commands from the CPU bus (duty magnitude plus direction) and produces the `duty`, `enable` and `dir` signals for the PWM stage and H-bridge.
- Slew-limits duty once per PWM period, so steps reach the motor as ramps rather than current spikes.
- On a direction reversal: ramps to zero, holds a dead interval with enable low, flips `dir`, then ramps back up.

Parameters:
- PERIOD, 1250, PWM period terminal count; matches the PWM counter, which counts 0..PERIOD.
- MAX_DUTY, 1251, commanded duty is clamped to this value; PERIOD+1 gives 100% on.
- STEP, 25, maximum duty change per period tick.
- DEAD_TICKS, 4, period ticks with enable=0 between ramp-down and direction flip.
- WDT_TICKS, 400, command timeout in period ticks; used only with RAMP_WATCHDOG_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_duty  in  32  target duty magnitude
- cmd_dir  in  1  target direction (1 = forward)
- duty  out  32  duty value to the PWM counter
- enable  out  1  enable to the PWM counter
- dir  out  1  H-bridge direction
- tick  out  1  one-cycle pulse at end of each PWM period
- busy  out  1  high in REV_DOWN or DEAD
- timeout  out  1  watchdog fired (sticky until next accepted command)

Behaviour:
- Reset (async, rst=1): duty=0, enable=0, dir=1, tick=0, busy=0, timeout=0, target=0, tgt_dir=1, period counter=0, state=IDLE.
- Period counter:
  - Free-runs 0..PERIOD from reset, regardless of state, then wraps to 0.
  - `tick` is registered and asserts for one cycle in the cycle after the counter holds PERIOD.
- `cmd_ready` = state not in {REV_DOWN, DEAD}; combinational from state.
- On accept:
  - target <= min(cmd_duty, MAX_DUTY).
  - tgt_dir <= cmd_dir.
  - Latest accepted command wins.
  - A command never changes duty directly; duty changes only on tick.
- States:
  - IDLE: enable=0, duty=0.
    - Accept with clamped duty>0: dir <= cmd_dir in the same cycle, enable=1 next cycle, go RUN.
    - Accept with clamped duty=0: updates target only.
  - RUN: enable=1.
    - On tick: duty moves toward target by min(STEP, |target-duty|). Unsigned arithmetic with no underflow below 0 and no overshoot past target.
    - Accept with tgt_dir != dir and duty>0: go REV_DOWN.
    - Accept with tgt_dir != dir and duty=0: dir flips immediately; stay RUN.
    - duty=0 and target=0 on a tick: go IDLE, enable=0 next cycle.
  - REV_DOWN: ramp toward 0 by STEP per tick. Target is kept for use after the flip. When duty reaches 0: enable=0, go DEAD.
  - DEAD: count DEAD_TICKS ticks. Then flip dir and go RUN (enable=1 in the same cycle as the flip); ramping toward target resumes on the next tick. DEAD_TICKS=0 flips on the next clock.
- Boundaries:
  - Accept and tick in the same cycle: the ramp step uses the old target; the new target applies from the next tick.
  - cmd_duty > MAX_DUTY: clamped.
  - STEP >= |delta|: duty lands exactly on target.
  - dir changes only while enable=0 or duty=0.
  - rst asserted mid-ramp or mid-DEAD: immediate return to reset values.

Optional Feature:
- RAMP_WATCHDOG_EN defined:
  - A counter of ticks since the last accepted command runs while state != IDLE.
  - When it reaches WDT_TICKS: target <= 0 and timeout <= 1, so the motor ramps down to IDLE.
  - The counter and timeout clear on the next accepted command.
- RAMP_WATCHDOG_EN undefined: no watchdog counter; timeout tied 0.

Decomposition:
- Shared package motor_pkg:
  - State enum: IDLE, RUN, REV_DOWN, DEAD.
  - DUTY_W=32.
  - Default PERIOD/MAX_DUTY constants shared with the PWM counter.
- One natural sub-module: duty_slew_step, a combinational next-duty function (duty, target, step → next duty, saturating).

Test Plan (bench overrides PERIOD=9, MAX_DUTY=10, STEP=3, DEAD_TICKS=2, WDT_TICKS=5):
- Command duty 8, dir 1 from IDLE → enable=1 next cycle; duty=3,6,8 on successive ticks, then holds 8.
- At duty 8, command duty 2 → duty=5,2 on next two ticks, never below 2.
- At duty 8 dir 1, command dir 0 duty 6 → busy=1, cmd_ready=0; duty 5,2,0; enable=0 for 2 ticks; dir=0 and enable=1; then duty 3,6.
- Command duty 50 → clamped; duty ramps to 10 and holds.
- Assert rst mid-DEAD → all outputs at reset values in the same cycle; state IDLE after release.
- RAMP_WATCHDOG_EN: duty 6, no further commands for 5 ticks → timeout=1; duty 3,0; IDLE. New command → timeout=0.
